// File: rtl/joy_pkg.sv
// Shared constants for the DB9 joystick conditioner: bit positions of the
// six active-low lines, line count, idle (all released) pattern, and a
// width helper used for counter sizing.
package joy_pkg;

   localparam int JOY_RIGHT  = 0;
   localparam int JOY_LEFT   = 1;
   localparam int JOY_DOWN   = 2;
   localparam int JOY_UP     = 3;
   localparam int JOY_FIRE   = 4;
   localparam int JOY_BTN2   = 5;

   localparam int JOY_NLINES = 6;

   localparam logic [JOY_NLINES-1:0] JOY_RELEASED = 6'b111111;

   // Bits needed to hold values 0..n-1, never less than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/joy_debounce_line.sv
// One DB9 line: two-flop synchroniser followed by a time-based debounce.
// The stable bit only follows the synchronised input once it has held the
// new level for DEBOUNCE_US consecutive microsecond ticks; any return to
// the stable level clears the count.
module joy_debounce_line
   import joy_pkg::*;
#(
   parameter int DEBOUNCE_US = 2000
) (
   input  logic sysclk,
   input  logic rst,
   input  logic us_tick,
   input  logic raw,
   output logic stable
);

   localparam int CW = cnt_width(DEBOUNCE_US + 1);

   logic          r_meta;
   logic          r_sync;
   logic          r_stable;
   logic [CW-1:0] r_cnt;

   // Bring the asynchronous raw line into the sysclk domain (idle = 1).
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= raw;
         r_sync <= r_meta;
      end
   end

   // Count whole ticks spent at the new level; accept it on the last one.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         r_stable <= 1'b1;
         r_cnt    <= '0;
      end else if (r_sync == r_stable) begin
         r_cnt <= '0;
      end else if (us_tick) begin
         if (r_cnt == CW'(DEBOUNCE_US - 1)) begin
            r_stable <= r_sync;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign stable = r_stable;

endmodule

// File: rtl/joy_db9_conditioner.sv
// DB9 joystick input conditioner: synchronises and debounces the six raw
// active-low lines and presents them, still active-low, to the core.
// A shared 1 us prescaler paces every line's debounce counter.
// Optional autofire on the fire button is built when AUTOFIRE_EN is defined.
module joy_db9_conditioner
   import joy_pkg::*;
#(
   parameter int MASTERCLK   = 28000000,
   parameter int DEBOUNCE_US = 2000,
   parameter int AUTOFIRE_HZ = 10
) (
   input  logic                  sysclk,
   input  logic                  rst,
   input  logic [JOY_NLINES-1:0] joy_in,
   input  logic                  autofire_en,
   output logic [JOY_NLINES-1:0] joy_out,
   output logic                  joy_changed
);

   localparam int PRESC = MASTERCLK / 1000000;
   localparam int PW    = cnt_width(PRESC);

   logic [PW-1:0]         r_presc;
   logic                  w_us_tick;
   logic [JOY_NLINES-1:0] w_stable;
   logic [JOY_NLINES-1:0] r_stable_prev;

   assign w_us_tick = (r_presc == PW'(PRESC - 1));

   // Free-running microsecond prescaler, 0..PRESC-1.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         r_presc <= '0;
      end else if (w_us_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + PW'(1);
      end
   end

   for (genvar g = 0; g < JOY_NLINES; g++) begin : g_line
      joy_debounce_line #(
         .DEBOUNCE_US (DEBOUNCE_US)
      ) u_line (
         .sysclk  (sysclk),
         .rst     (rst),
         .us_tick (w_us_tick),
         .raw     (joy_in[g]),
         .stable  (w_stable[g])
      );
   end

   // Previous-cycle copy of the debounced state for change detection.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         r_stable_prev <= JOY_RELEASED;
      end else begin
         r_stable_prev <= w_stable;
      end
   end

   // Any debounced bit change (not autofire) gives one pulse.
   assign joy_changed = |(w_stable ^ r_stable_prev);

`ifdef AUTOFIRE_EN
   localparam int AF_HALF = MASTERCLK / (2 * AUTOFIRE_HZ);
   localparam int AW      = cnt_width(AF_HALF);

   logic [AW-1:0] r_af_cnt;
   logic          r_af_phase;
   logic          w_af_active;

   assign w_af_active = ~w_stable[JOY_FIRE] & autofire_en;

   // Half-period timer and phase. Both sit at 0 whenever autofire is not
   // active, so a fresh press or enable always starts in the pressed phase.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         r_af_cnt   <= '0;
         r_af_phase <= 1'b0;
      end else if (!w_af_active) begin
         r_af_cnt   <= '0;
         r_af_phase <= 1'b0;
      end else if (r_af_cnt == AW'(AF_HALF - 1)) begin
         r_af_cnt   <= '0;
         r_af_phase <= ~r_af_phase;
      end else begin
         r_af_cnt <= r_af_cnt + AW'(1);
      end
   end

   // Debounced state, with fire replaced by the autofire phase while active.
   always_comb begin
      joy_out = w_stable;
      if (w_af_active) begin
         joy_out[JOY_FIRE] = r_af_phase;
      end
   end
`else
   logic w_unused;

   assign w_unused = autofire_en ^ 1'(AUTOFIRE_HZ > 0);
   assign joy_out  = w_stable;
`endif

endmodule

// File: tb/tb_joy_db9_conditioner.sv
// Directed bench for joy_db9_conditioner. 4 clocks per us, 3 us debounce,
// 4-cycle autofire half-period. Build with AUTOFIRE_EN to check autofire.
module tb_joy_db9_conditioner;
   import joy_pkg::*;

   logic       clk;
   logic       rst;
   logic [5:0] joy_in;
   logic       autofire_en;
   logic [5:0] joy_out;
   logic       joy_changed;

   int n_cmp = 0;
   int n_bad = 0;

   joy_db9_conditioner #(
      .MASTERCLK   (4000000),
      .DEBOUNCE_US (3),
      .AUTOFIRE_HZ (500000)
   ) dut (
      .sysclk      (clk),
      .rst         (rst),
      .joy_in      (joy_in),
      .autofire_en (autofire_en),
      .joy_out     (joy_out),
      .joy_changed (joy_changed)
   );

   // Clock and reset defaults
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Step cycles until joy_out[idx] reaches val; n = samples taken
   // (budget+1 when the bound expires), pulses = joy_changed highs seen.
   task automatic wait_out_bit(input int idx, input logic val, input int budget,
                               output int n, output int pulses);
      bit done = 0;
      n = budget + 1;
      pulses = 0;
      for (int k = 1; k <= budget && !done; k++) begin
         @(posedge clk); #1;
         if (joy_changed === 1'b1) pulses++;
         if (joy_out[idx] === val) begin
            n = k;
            done = 1;
         end
      end
   endtask

   // Step cycles until joy_changed is seen high; n = budget+1 on expiry.
   task automatic wait_pulse(input int budget, output int n);
      bit done = 0;
      n = budget + 1;
      for (int k = 1; k <= budget && !done; k++) begin
         @(posedge clk); #1;
         if (joy_changed === 1'b1) begin
            n = k;
            done = 1;
         end
      end
   endtask

   task automatic test_reset();
      int n, p;
      rst = 1'b1; joy_in = 6'h3F; autofire_en = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      n_cmp++; if (joy_out !== 6'h3F) begin n_bad++; $display("FAIL reset_out got %b want 111111", joy_out); end
      n_cmp++; if (joy_changed !== 1'b0) begin n_bad++; $display("FAIL reset_chg got %b want 0", joy_changed); end
      joy_in = 6'h00;
      wait_out_bit(JOY_RIGHT, 1'b0, 20, n, p);
      n_cmp++; if (joy_out !== 6'h00) begin n_bad++; $display("FAIL pre_reset_low got %b want 000000", joy_out); end
      // Asynchronous assert in mid-cycle
      @(negedge clk); #1 rst = 1'b1;
      #1;
      n_cmp++; if (joy_out !== 6'h3F) begin n_bad++; $display("FAIL async_reset_out got %b want 111111", joy_out); end
      n_cmp++; if (joy_changed !== 1'b0) begin n_bad++; $display("FAIL async_reset_chg got %b want 0", joy_changed); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      wait_out_bit(JOY_RIGHT, 1'b0, 20, n, p);
      n_cmp++; if (n < 11 || n > 14) begin n_bad++; $display("FAIL post_reset_latency got %0d want 11..14", n); end
      n_cmp++; if (joy_out !== 6'h00) begin n_bad++; $display("FAIL post_reset_out got %b want 000000", joy_out); end
      n_cmp++; if (p !== 1) begin n_bad++; $display("FAIL post_reset_pulses got %0d want 1", p); end
      @(posedge clk); #1;
      n_cmp++; if (joy_changed !== 1'b0) begin n_bad++; $display("FAIL post_reset_pulse_width got %b want 0", joy_changed); end
      joy_in = 6'h3F;
      wait_out_bit(JOY_RIGHT, 1'b1, 20, n, p);
      n_cmp++; if (joy_out !== 6'h3F || p !== 1) begin n_bad++; $display("FAIL restore_release got %b/%0d want 111111/1", joy_out, p); end
      repeat (4) @(posedge clk);
   endtask

   task automatic test_glitch();
      int p = 0;
      bit moved = 0;
      @(posedge clk); #1 joy_in[JOY_UP] = 1'b0;
      for (int k = 0; k < 30; k++) begin
         if (k == 8) joy_in[JOY_UP] = 1'b1;
         @(posedge clk); #1;
         if (joy_changed === 1'b1) p++;
         if (joy_out !== 6'h3F) moved = 1;
      end
      n_cmp++; if (moved !== 1'b0) begin n_bad++; $display("FAIL glitch_out got moved=%0d want 0", moved); end
      n_cmp++; if (p !== 0) begin n_bad++; $display("FAIL glitch_pulses got %0d want 0", p); end
   endtask

   task automatic test_fire_press_release();
      int n, p, extra;
      @(posedge clk); #1 joy_in[JOY_FIRE] = 1'b0;
      wait_out_bit(JOY_FIRE, 1'b0, 20, n, p);
      n_cmp++; if (n < 10 || n > 14) begin n_bad++; $display("FAIL fire_press_latency got %0d want 10..14", n); end
      n_cmp++; if (p !== 1) begin n_bad++; $display("FAIL fire_press_pulses got %0d want 1", p); end
      n_cmp++; if (joy_out !== 6'b101111) begin n_bad++; $display("FAIL fire_press_out got %b want 101111", joy_out); end
      extra = 0;
      for (int k = n; k < 40; k++) begin
         @(posedge clk); #1;
         if (joy_changed === 1'b1) extra++;
      end
      n_cmp++; if (extra !== 0 || joy_out !== 6'b101111) begin n_bad++; $display("FAIL fire_hold got %0d pulses out %b want 0 / 101111", extra, joy_out); end
      joy_in[JOY_FIRE] = 1'b1;
      wait_out_bit(JOY_FIRE, 1'b1, 20, n, p);
      n_cmp++; if (n < 10 || n > 14) begin n_bad++; $display("FAIL fire_release_latency got %0d want 10..14", n); end
      n_cmp++; if (p !== 1) begin n_bad++; $display("FAIL fire_release_pulses got %0d want 1", p); end
      @(posedge clk); #1;
      n_cmp++; if (joy_changed !== 1'b0) begin n_bad++; $display("FAIL fire_release_pulse_width got %b want 0", joy_changed); end
   endtask

   task automatic test_bounce();
      int n, p = 0;
      bit moved = 0;
      @(posedge clk); #1;
      for (int k = 0; k < 30; k++) begin
         if (k % 3 == 0) joy_in[JOY_RIGHT] = ~joy_in[JOY_RIGHT];
         @(posedge clk); #1;
         if (joy_changed === 1'b1) p++;
         if (joy_out !== 6'h3F) moved = 1;
      end
      n_cmp++; if (moved !== 1'b0 || p !== 0) begin n_bad++; $display("FAIL bounce_quiet got moved=%0d pulses=%0d want 0/0", moved, p); end
      joy_in[JOY_RIGHT] = 1'b0;
      wait_out_bit(JOY_RIGHT, 1'b0, 20, n, p);
      n_cmp++; if (n < 10 || n > 14) begin n_bad++; $display("FAIL bounce_latency got %0d want 10..14", n); end
      n_cmp++; if (p !== 1 || joy_out !== 6'b111110) begin n_bad++; $display("FAIL bounce_settle got %b/%0d want 111110/1", joy_out, p); end
      joy_in[JOY_RIGHT] = 1'b1;
      wait_out_bit(JOY_RIGHT, 1'b1, 20, n, p);
      n_cmp++; if (joy_out !== 6'h3F) begin n_bad++; $display("FAIL bounce_restore got %b want 111111", joy_out); end
   endtask

   task automatic test_simultaneous();
      int n, p;
      @(posedge clk); #1;
      joy_in[JOY_DOWN] = 1'b0;
      joy_in[JOY_LEFT] = 1'b0;
      wait_out_bit(JOY_DOWN, 1'b0, 20, n, p);
      n_cmp++; if (joy_out !== 6'b111001) begin n_bad++; $display("FAIL simul_out got %b want 111001", joy_out); end
      n_cmp++; if (p !== 1) begin n_bad++; $display("FAIL simul_pulses got %0d want 1", p); end
      @(posedge clk); #1;
      n_cmp++; if (joy_changed !== 1'b0) begin n_bad++; $display("FAIL simul_pulse_width got %b want 0", joy_changed); end
      joy_in[JOY_DOWN] = 1'b1;
      joy_in[JOY_LEFT] = 1'b1;
      wait_out_bit(JOY_DOWN, 1'b1, 20, n, p);
      n_cmp++; if (joy_out !== 6'h3F || p !== 1) begin n_bad++; $display("FAIL simul_release got %b/%0d want 111111/1", joy_out, p); end
   endtask

   task automatic test_autofire();
      int n, p;
      logic exp;
      repeat (4) @(posedge clk);
      #1 autofire_en = 1'b1;
      @(posedge clk); #1 joy_in[JOY_FIRE] = 1'b0;
      wait_out_bit(JOY_FIRE, 1'b0, 20, n, p);
      n_cmp++; if (n < 10 || n > 14) begin n_bad++; $display("FAIL af_press_latency got %0d want 10..14", n); end
      n_cmp++; if (p !== 1) begin n_bad++; $display("FAIL af_press_pulses got %0d want 1", p); end
      for (int k = 1; k < 24; k++) begin
         @(posedge clk); #1;
`ifdef AUTOFIRE_EN
         exp = ((k / 4) % 2 == 1) ? 1'b1 : 1'b0;
`else
         exp = 1'b0;
`endif
         n_cmp++; if (joy_out[JOY_FIRE] !== exp) begin n_bad++; $display("FAIL af_phase k=%0d got %b want %b", k, joy_out[JOY_FIRE], exp); end
         n_cmp++; if (joy_changed !== 1'b0) begin n_bad++; $display("FAIL af_no_pulse k=%0d got %b want 0", k, joy_changed); end
      end
      joy_in[JOY_FIRE] = 1'b1;
      wait_pulse(20, n);
      n_cmp++; if (n < 10 || n > 14) begin n_bad++; $display("FAIL af_release_latency got %0d want 10..14", n); end
      n_cmp++; if (joy_out !== 6'h3F) begin n_bad++; $display("FAIL af_release_out got %b want 111111", joy_out); end
      @(posedge clk); #1;
      n_cmp++; if (joy_changed !== 1'b0 || joy_out !== 6'h3F) begin n_bad++; $display("FAIL af_after_release got %b/%b want 0/111111", joy_changed, joy_out); end
      autofire_en = 1'b0;
   endtask

   // Sequence of scenarios and final report
   initial begin
      test_reset();
      test_glitch();
      test_fire_press_release();
      test_bounce();
      test_simultaneous();
      test_autofire();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/joy_db9_conditioner.md
Name: joy_db9_conditioner

Overview:
Input stage directly upstream of the zxuno core's joystick pins (joyup/joydown/joyleft/joyright/joyfire/joybtn2). It takes the six raw, active-low DB9 lines and performs:
- 2-flop synchronisation
- per-line time-based debounce (common 1 µs prescaler)
- optional autofire on the fire button

Outputs stay active-low, so they wire 1:1 into the core in place of the raw pins.

Parameters:
MASTERCLK, 28000000, sysclk frequency in Hz; must be an integer multiple of 1000000 and at least 1000000.
DEBOUNCE_US, 2000, time in µs a synchronised line must hold a new level before the output follows; at least 1.
AUTOFIRE_HZ, 10, autofire square-wave frequency in Hz; used only with the optional feature.

Ports:
sysclk  input  1  system clock (single clock domain)
rst  input  1  asynchronous, active-high reset
joy_in  input  6  raw DB9 lines, active-low, asynchronous; [5]=btn2 [4]=fire [3]=up [2]=down [1]=left [0]=right
autofire_en  input  1  synchronous to sysclk; enables autofire; ignored unless AUTOFIRE_EN is defined
joy_out  output  6  debounced lines, active-low, same bit order as joy_in
joy_changed  output  1  one-cycle pulse when any bit of the debounced state changes

Behaviour:
Reset (async assert, release sampled on sysclk):
- sync flops = 1, stable state = 6'b111111, joy_out = 6'b111111, joy_changed = 0.
- Prescaler, per-line counters and autofire counter = 0.
- Reset mid-debounce discards the pending change.

Synchroniser:
- Two flops per line; sync[i] lags joy_in[i] by 2 cycles.

Prescaler:
- Counts 0..MASTERCLK/1000000-1 and wraps.
- us_tick is high for one cycle when the count is at max.

Per-line debounce (all six lines identical and independent):
- State is stable[i] plus a counter cnt[i] of width clog2(DEBOUNCE_US+1).
- sync[i]==stable[i]: cnt[i] <= 0 on every cycle, tick or not.
- sync[i]!=stable[i] and us_tick and cnt[i]==DEBOUNCE_US-1: stable[i] <= sync[i], cnt[i] <= 0.
- sync[i]!=stable[i] and us_tick otherwise: cnt[i] <= cnt[i]+1.
- No tick: cnt[i] holds.
- A glitch shorter than the debounce window resets the count. The first tick after a change may be partial, so accepted hold time is in (DEBOUNCE_US-1, DEBOUNCE_US] µs.
- cnt never exceeds DEBOUNCE_US-1, so there is no wrap.

Outputs:
- joy_out is stable, registered; with the feature, bit 4 is modified as below.
- joy_changed = 1 in the cycle after any stable bit changes, i.e. when stable differs from its previous-cycle copy. Multiple bits changing on the same tick give a single pulse.
- Autofire toggling does not pulse joy_changed.

Latency from a clean input edge:
- 2 sync cycles, plus the wait to DEBOUNCE_US ticks, plus 0 cycles (joy_out comes from the same register as stable).

Optional Feature:
Macro AUTOFIRE_EN.

Defined:
- Half-period counter of MASTERCLK/(2*AUTOFIRE_HZ) cycles and a phase flop.
- While stable[4]==0 and autofire_en==1:
  - joy_out[4] = phase.
  - phase toggles at each half-period wrap.
- On the falling edge of stable[4], or when autofire_en rises:
  - counter is cleared and phase = 0, so the press is reported immediately.
- Otherwise joy_out[4] = stable[4], and counter/phase are held at 0.
- Both the counter and the phase reset to 0.

Undefined:
- No autofire logic.
- autofire_en is unused.
- joy_out[4] = stable[4].

Decomposition:
Shared package joy_pkg holds:
- bit-index constants JOY_RIGHT=0, JOY_LEFT=1, JOY_DOWN=2, JOY_UP=3, JOY_FIRE=4, JOY_BTN2=5
- JOY_NLINES=6
- JOY_RELEASED=6'b111111

One sub-module, joy_debounce_line:
- Contents: sync pair, counter and stable bit for a single line.
- Inputs: sysclk, rst, us_tick, raw.
- Output: stable.
- Instantiated 6 times via generate.
- Prescaler, change detector and autofire stay in the top module.

Test Plan:
Bench parameters unless noted: MASTERCLK=4000000 (4 cycles per µs), DEBOUNCE_US=3, AUTOFIRE_HZ=500000 (4-cycle half-period).
1. Reset: assert rst asynchronously mid-cycle with joy_in=0 -> joy_out=6'b111111 and joy_changed=0 immediately. After release, joy_in held 0 -> joy_out=6'b000000 within 2+12 cycles, with exactly one joy_changed pulse.
2. Glitch rejection: joy_in[3] low for 8 cycles, then high -> joy_out stays 6'b111111 and joy_changed never pulses.
3. Clean press/release on fire: joy_in[4] low for 40 cycles -> joy_out[4] falls 10..14 cycles after the input edge, rises again 10..14 cycles after release, and each change gives one 1-cycle joy_changed pulse.
4. Bounce: joy_in[0] toggles every 3 cycles for 30 cycles, then settles low -> a single transition, counted from the final edge, with no intermediate output changes.
5. Simultaneous: joy_in[2] and joy_in[1] fall on the same cycle -> both joy_out bits fall on the same cycle, with a single joy_changed pulse.
6. AUTOFIRE_EN defined, autofire_en=1, fire held:
   - joy_out[4] = 0 at the debounced press, then toggles every 4 cycles.
   - On release, joy_out[4] = 1 when stable[4] rises.
   - joy_changed pulses only on the press and the release.
   - With the macro undefined, the same stimulus gives a constant 0 while held.
